// File: rtl/act_mem_readout.sv
// Activation-memory read-back path: reads a contiguous run of rows from SRAM
// and streams them to the external host port through a 2-entry output buffer.
module act_mem_readout #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14,
   parameter int LEN_WIDTH  = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                  mem_rd_gnt,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LEN_WIDTH-1:0]  rd_left_q, rd_left_d;
   logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            occ_q, occ_d;
   logic                  head_q, head_d;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic [DATA_WIDTH-1:0] fifo_d [2];

   logic accept;
   logic pop;
   logic start_go;
   logic tail;

   assign accept   = mem_rd_en & mem_rd_gnt;
   assign pop      = out_valid & out_ready;
   assign start_go = (state_q == IDLE) & start;
   assign tail     = head_q ^ occ_q[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (length == '0) ? DONE : READ;
         READ:    if (accept && rd_left_q == LEN_ONE) state_d = DRAIN;
         DRAIN:   if (pop && out_left_q == LEN_ONE) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A request is only issued when the row it returns is guaranteed a free slot.
   always_comb begin
      mem_rd_en   = (state_q == READ) &&
                    (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);
      mem_rd_addr = rd_ptr_q;
      out_valid   = (occ_q != 2'd0);
      out_data    = fifo_q[head_q];
      out_last    = out_valid && (out_left_q == LEN_ONE);
      busy        = (state_q != IDLE) && (state_q != DONE);
      done        = (state_q == DONE);
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      rd_left_d  = rd_left_q;
      out_left_d = out_left_q;
      head_d     = head_q;
      fifo_d     = fifo_q;
      inflight_d = accept;
      if (start_go) begin
         rd_ptr_d   = base_addr;
         rd_left_d  = length;
         out_left_d = length;
      end
      if (accept) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         rd_left_d = rd_left_q - LEN_ONE;
      end
      if (inflight_q) begin
         fifo_d[tail] = mem_rd_data;
      end
      if (pop) begin
         head_d     = ~head_q;
         out_left_d = out_left_q - LEN_ONE;
      end
      occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
   end

   // Clearing inflight on reset drops any SRAM data still on its way back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         rd_left_q  <= '0;
         out_left_q <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         head_q     <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         rd_left_q  <= rd_left_d;
         out_left_q <= out_left_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         head_q     <= head_d;
         fifo_q[0]  <= fifo_d[0];
         fifo_q[1]  <= fifo_d[1];
      end
   end

endmodule

// File: tb/tb_act_mem_readout.sv
// Randomized self-checking bench for act_mem_readout against a row-sequence
// reference model and a behavioural 1-cycle-latency SRAM.
module tb_act_mem_readout;

   localparam int DW = 32;
   localparam int AW = 14;
   localparam int LW = 15;
   localparam int MEM_ROWS = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] baseAddr;
   logic [LW-1:0] length;
   logic          memRdEn;
   logic [AW-1:0] memRdAddr;
   logic          memRdGnt;
   logic [DW-1:0] memRdData;
   logic          outValid;
   logic          outReady;
   logic [DW-1:0] outData;
   logic          outLast;
   logic          busy;
   logic          done;

   act_mem_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (baseAddr),
      .length      (length),
      .mem_rd_en   (memRdEn),
      .mem_rd_addr (memRdAddr),
      .mem_rd_gnt  (memRdGnt),
      .mem_rd_data (memRdData),
      .out_valid   (outValid),
      .out_ready   (outReady),
      .out_data    (outData),
      .out_last    (outLast),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] sram [MEM_ROWS];

   int assertCount = 0;
   int failCount   = 0;

   // Reference model: the expected stream is simply sram[base + i] for i < len.
   logic [AW-1:0] curBase;
   int            curLen;
   int            reqCount;
   int            popCount;
   int            inflightNow;
   bit            busyExp;
   bit            doneExp;
   bit            pendValid;
   logic [AW-1:0] pendAddr;
   bit            lastNoGnt;
   logic [AW-1:0] lastNoGntAddr;
   bit            lastStall;
   logic [DW-1:0] lastStallData;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      curBase     = '0;
      curLen      = 0;
      reqCount    = 0;
      popCount    = 0;
      inflightNow = 0;
      busyExp     = 1'b0;
      doneExp     = 1'b0;
      pendValid   = 1'b0;
      pendAddr    = '0;
      lastNoGnt   = 1'b0;
      lastStall   = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_memRdEn"},   memRdEn,   0);
      checkOutput({tag, "_memRdAddr"}, memRdAddr, 0);
      checkOutput({tag, "_outValid"},  outValid,  0);
      checkOutput({tag, "_outData"},   outData,   0);
      checkOutput({tag, "_outLast"},   outLast,   0);
      checkOutput({tag, "_busy"},      busy,      0);
      checkOutput({tag, "_done"},      done,      0);
   endtask

   // One clock cycle: drive inputs at the falling edge, check, advance the model.
   task automatic applyStimulus(input bit startIn, input logic [AW-1:0] b,
                                input logic [LW-1:0] l, input bit gntIn, input bit readyIn);
      int  occ;
      int  nextInflight;
      bit  nextDone;
      bit  nextBusy;
      @(negedge clk);
      memRdData = pendValid ? sram[pendAddr] : DW'($urandom);
      pendValid = 1'b0;
      start     = startIn;
      baseAddr  = b;
      length    = l;
      memRdGnt  = gntIn;
      outReady  = readyIn;
      #1;
      checkOutput("busy", busy, busyExp);
      checkOutput("done", done, doneExp);
      occ = reqCount - inflightNow - popCount;
      checkOutput("outValid", outValid, occ != 0);
      if (occ > 2) checkOutput("occupancy", occ, 2);
      if (!busyExp) checkOutput("enIdle", memRdEn, 0);
      if (lastNoGnt) begin
         checkOutput("gntHoldEn", memRdEn, 1);
         checkOutput("gntHoldAddr", memRdAddr, lastNoGntAddr);
      end
      if (lastStall) checkOutput("stallData", outData, lastStallData);
      nextInflight = 0;
      if (memRdEn && memRdGnt) begin
         checkOutput("rdAddr", memRdAddr, AW'(curBase + reqCount));
         checkOutput("reqBound", reqCount < curLen, 1);
         pendValid    = 1'b1;
         pendAddr     = memRdAddr;
         reqCount++;
         nextInflight = 1;
      end
      if (outValid) checkOutput("outLast", outLast, popCount == curLen - 1);
      else          checkOutput("lastLow", outLast, 0);
      nextDone = 1'b0;
      if (outValid && outReady) begin
         checkOutput("outData", outData, sram[AW'(curBase + popCount)]);
         popCount++;
         if (popCount == curLen) nextDone = 1'b1;
      end
      nextBusy = busyExp && !nextDone;
      if (startIn && !busyExp && !doneExp) begin
         curBase  = b;
         curLen   = int'(l);
         reqCount = 0;
         popCount = 0;
         if (l == '0) nextDone = 1'b1;
         else         nextBusy = 1'b1;
      end
      lastNoGnt     = memRdEn && !memRdGnt;
      lastNoGntAddr = memRdAddr;
      lastStall     = outValid && !outReady;
      lastStallData = outData;
      inflightNow   = nextInflight;
      doneExp       = nextDone;
      busyExp       = nextBusy;
   endtask

   // mode 0: gnt/ready high, 1: ready 1,0,0,1, 2: gnt low 3 cycles on 2nd request
   // plus a stray start, 3: random gnt/ready.
   task automatic runTransfer(input logic [AW-1:0] b, input int l, input int mode,
                              input int abortAfter);
      int            cycles = 0;
      int            gLow   = 0;
      bit            seenDone = 1'b0;
      bit            st, g, r;
      logic [AW-1:0] bAddr;
      while (!seenDone && cycles < 600) begin
         st    = (cycles == 0) || (mode == 2 && cycles == 4);
         bAddr = (cycles == 0) ? b : AW'(14'h0100);
         g = 1'b1;
         r = 1'b1;
         case (mode)
            1: r = ((cycles % 4) == 0) || ((cycles % 4) == 3);
            2: if (cycles > 0 && reqCount == 1 && gLow < 3) g = 1'b0;
            3: begin
               g = ($urandom_range(0, 3) != 0);
               r = ($urandom_range(0, 2) != 0);
            end
            default: ;
         endcase
         applyStimulus(st, bAddr, LW'(l), g, r);
         if (lastNoGnt) gLow++;
         if (abortAfter > 0 && popCount >= abortAfter) return;
         if (doneExp) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
            seenDone = 1'b1;
         end
         cycles++;
      end
      if (!seenDone) checkOutput("timeout", 0, 1);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < MEM_ROWS; i++) sram[i] = DW'($urandom);
      resetModel();
      reset     = 1'b0;
      start     = 1'b0;
      baseAddr  = '0;
      length    = '0;
      memRdGnt  = 1'b0;
      memRdData = '0;
      outReady  = 1'b0;
      #12;
      checkResetOutputs("reset");
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] basic transfer base 0x10 len 4");
      runTransfer(AW'(14'h0010), 4, 0, 0);
      $display("[TB] zero-length transfer");
      runTransfer(AW'(14'h0055), 0, 0, 0);
      $display("[TB] address wrap base 0x3FFE len 4");
      runTransfer(AW'(14'h3FFE), 4, 0, 0);
      $display("[TB] ready toggling len 8");
      runTransfer(AW'(14'h0400), 8, 1, 0);
      $display("[TB] grant stall and ignored start len 3");
      runTransfer(AW'(14'h0600), 3, 2, 0);

      $display("[TB] reset mid-transfer");
      runTransfer(AW'(14'h0200), 10, 0, 2);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 checkResetOutputs("abort");
      resetModel();
      @(negedge clk);
      reset = 1'b1;
      runTransfer(AW'(14'h0020), 2, 0, 0);

      $display("[TB] randomized transfers");
      for (int t = 0; t < 8; t++) begin
         runTransfer(AW'($urandom), int'($urandom_range(1, 24)), 3, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
